// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - receive-side decoder for a multiplexed 7-segment display bus
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_dig_en,
  output logic [4*NUM_DIGITS-1:0] o_hexa,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic [NUM_DIGITS-1:0]   o_valid,
  output logic                    o_update,
  output logic [IDX_W-1:0]        o_update_idx,
  output logic                    o_err
);

  localparam int SW    = 8 + NUM_DIGITS;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_DONE = CNT_W'(STABLE_CYCLES);
  localparam logic [WD_W-1:0]       WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]       WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  // Segment pattern -> {legal, hex value}; lit segments are 0 on the bus.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h18:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h27:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [SW-1:0]           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]         wd_q [NUM_DIGITS];
  logic [WD_W-1:0]         wd_d [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] hexa_q, hexa_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, valid_q, valid_d;
  logic                    update_q, update_d, err_q, err_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [7:0]              s_seg;
  logic [NUM_DIGITS-1:0]   s_dig;
  logic                    commit;
  logic                    one_hot;
  logic [IDX_W-1:0]        c_idx;
  logic [4:0]              dec;

  assign s_seg = sync2_q[SW-1:NUM_DIGITS];
  assign s_dig = sync2_q[NUM_DIGITS-1:0];

  // Two-stage synchronizer for the whole sampled bus (segments and strobes together)
  always_comb begin
    sync1_d = {i_seg, i_dig_en};
    sync2_d = sync1_q;
  end

  // Run-length tracker: a pattern must repeat STABLE_CYCLES samples before it commits once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    commit  = 1'b0;
    if (s_dig == '0) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (!(state_q inside {ST_TRACK, ST_HELD}) || (sync2_q != prev_q)) begin
      state_d = ST_TRACK;
      prev_d  = sync2_q;
      cnt_d   = CNT_ONE;
    end else if (state_q == ST_TRACK) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_d == CNT_DONE) begin
        commit  = 1'b1;
        state_d = ST_HELD;
      end
    end
  end

  // Strobe classification and pattern decode of the committing sample
  always_comb begin
    one_hot = (s_dig != '0) && ((s_dig & (s_dig - DIG_ONE)) == '0);
    c_idx   = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (s_dig[d]) c_idx = IDX_W'(d);
    end
    dec = seg_decode(s_seg[6:0]);
  end

  // Per-digit state update: watchdog expiry first, so a same-cycle commit overrides it
  always_comb begin
    hexa_d   = hexa_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      wd_d[d] = (wd_q[d] == WD_LIMIT) ? wd_q[d] : wd_q[d] + WD_ONE;
      if (wd_d[d] == WD_LIMIT) valid_d[d] = 1'b0;
    end
    if (commit) begin
      if (!one_hot) begin
        err_d = 1'b1;
      end else begin
        wd_d[c_idx] = '0;
        if (s_seg[6:0] == 7'h7F) begin
          blank_d[c_idx]        = 1'b1;
          hexa_d[c_idx*4 +: 4]  = 4'h0;
          dp_d[c_idx]           = s_seg[7];
          valid_d[c_idx]        = 1'b1;
          update_d              = 1'b1;
          idx_d                 = c_idx;
        end else if (dec[4]) begin
          blank_d[c_idx]        = 1'b0;
          hexa_d[c_idx*4 +: 4]  = dec[3:0];
          dp_d[c_idx]           = s_seg[7];
          valid_d[c_idx]        = 1'b1;
          update_d              = 1'b1;
          idx_d                 = c_idx;
        end else begin
          err_d          = 1'b1;
          valid_d[c_idx] = 1'b0;
        end
      end
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hexa_q   <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) wd_q[d] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hexa_q   <= hexa_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      for (int d = 0; d < NUM_DIGITS; d++) wd_q[d] <= wd_d[d];
    end
  end

  assign o_hexa       = hexa_q;
  assign o_dp         = dp_q;
  assign o_blank      = blank_q;
  assign o_valid      = valid_q;
  assign o_update     = update_q;
  assign o_update_idx = idx_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int ST = 16;
  localparam int TO = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg = 8'h00;
  logic [3:0]  dig = 4'h0;
  logic [15:0] o_hexa;
  logic [3:0]  o_dp, o_blank, o_valid;
  logic        o_update, o_err;
  logic [1:0]  o_update_idx;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seg(seg), .i_dig_en(dig),
    .o_hexa(o_hexa), .o_dp(o_dp), .o_blank(o_blank), .o_valid(o_valid),
    .o_update(o_update), .o_update_idx(o_update_idx), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    bit          has_digit;
    bit          is_blank;
    int          idx;
    logic [15:0] hexa;
    logic [3:0]  dp;
    logic [3:0]  blank;
    bit          valid;
    logic [7:0]  seg;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  upd_cyc[ND];
  int  fall_cyc[ND];

  logic [6:0] codes[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  // reference model state: per-digit display contents and the current pin run
  logic [3:0]  m_hexa[ND];
  logic        m_dp[ND];
  logic        m_blank[ND];
  logic [11:0] m_cur;
  bit          m_cur_ok;
  int          m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_hexa[d] = 4'h0; m_dp[d] = 1'b0; m_blank[d] = 1'b0;
    end
    m_cur_ok = 1'b0;
    m_run = 0;
  endtask

  task automatic model_commit(input logic [7:0] s, input logic [3:0] d);
    ev_t e;
    int hit;
    e.seg = s; e.is_blank = 1'b0; e.valid = 1'b0; e.idx = 0;
    if ($countones(d) != 1) begin
      e.is_err = 1'b1; e.has_digit = 1'b0;
    end else begin
      e.has_digit = 1'b1;
      for (int k = 0; k < ND; k++) if (d[k]) e.idx = k;
      hit = -1;
      for (int k = 0; k < 16; k++) if (codes[k] == s[6:0]) hit = k;
      if (s[6:0] == 7'h7F) begin
        e.is_err = 1'b0; e.is_blank = 1'b1; e.valid = 1'b1;
        m_hexa[e.idx] = 4'h0; m_blank[e.idx] = 1'b1; m_dp[e.idx] = s[7];
      end else if (hit >= 0) begin
        e.is_err = 1'b0; e.valid = 1'b1;
        m_hexa[e.idx] = 4'(hit); m_blank[e.idx] = 1'b0; m_dp[e.idx] = s[7];
      end else begin
        e.is_err = 1'b1; e.valid = 1'b0;
      end
    end
    for (int k = 0; k < ND; k++) begin
      e.hexa[k*4 +: 4] = m_hexa[k];
      e.dp[k] = m_dp[k];
      e.blank[k] = m_blank[k];
    end
    q.push_back(e);
  endtask

  // apply a pin pattern for n cycles; a run of >= ST identical samples commits once
  task automatic issue(input logic [7:0] s, input logic [3:0] d, input int n);
    logic [11:0] v;
    int old;
    v = {s, d};
    old = (m_cur_ok && v == m_cur) ? m_run : 0;
    m_cur = v; m_cur_ok = 1'b1; m_run = old + n;
    if (d != 4'h0 && old < ST && m_run >= ST) model_commit(s, d);
    seg = s; dig = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("queue_drained_before_reset", q.size(), 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_hexa", o_hexa, 0);
    chk("rst_async_flags", {o_dp, o_blank, o_valid}, 0);
    chk("rst_async_pulses", {o_update, o_err, o_update_idx}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // monitor: pops the scoreboard whenever the DUT reports a commit
  initial begin
    ev_t e;
    logic [3:0] pv;
    pv = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < ND; d++) begin upd_cyc[d] = -1; fall_cyc[d] = -1; end
        pv = 4'h0;
      end else begin
        for (int d = 0; d < ND; d++) if (pv[d] && !o_valid[d]) fall_cyc[d] = cyc;
        pv = o_valid;
        if (o_update || o_err) begin
          chk("update_err_exclusive", o_update & o_err, 0);
          if (q.size() == 0) begin
            chk("unexpected_pulse", {o_update, o_err}, 2'b00);
          end else begin
            e = q.pop_front();
            chk("pulse_is_err", o_err, e.is_err);
            chk("pulse_is_update", o_update, !e.is_err);
            chk("hexa", o_hexa, e.hexa);
            chk("dp", o_dp, e.dp);
            chk("blank", o_blank, e.blank);
            if (e.has_digit) chk("valid_bit", o_valid[e.idx], e.valid);
            if (!e.is_err) begin
              chk("update_idx", o_update_idx, e.idx);
              upd_cyc[e.idx] = cyc;
              if (!e.is_blank)
                chk("roundtrip", {o_dp[e.idx], codes[o_hexa[e.idx*4 +: 4]]}, e.seg);
            end
          end
        end
      end
    end
  end

  initial begin
    int start;
    logic [7:0] rs, ps;
    logic [3:0] rd, pd;
    int rn, a, b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hexa", o_hexa, 0);
    chk("reset_flags", {o_dp, o_blank, o_valid}, 0);
    chk("reset_pulses", {o_update, o_err, o_update_idx}, 0);
    rst_n = 1'b1;

    // single legal digit, latency from pin change to commit
    start = cyc;
    issue(8'hA4, 4'b0010, 20);
    chk("latency_legal", upd_cyc[1] - start, 18);
    chk("legal_hexa1", o_hexa[7:4], 4'h2);
    chk("legal_dp_valid", {o_dp[1], o_valid[1]}, 2'b11);

    // full sweep of codes and blank on every digit, both dp values
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 17; c++)
        for (int p = 0; p < 2; p++)
          issue({p[0], (c == 16) ? 7'h7F : codes[c]}, 4'(1 << d), 17);

    // glitch, run-length boundary, illegal pattern, strobe faults
    issue(8'h40, 4'b0001, 10);
    issue(8'h79, 4'b0001, 20);
    issue(8'h19, 4'b0100, 15);
    issue(8'h12, 4'b0100, 16);
    issue(8'h00, 4'b0000, 5);
    issue(8'h55, 4'b0001, 20);
    issue(8'h79, 4'b0011, 20);
    issue(8'h79, 4'b0000, 20);
    chk("queue_drained_faults", q.size(), 0);

    // asynchronous reset in the middle of a run
    issue(8'h30, 4'b0100, 20);
    issue(8'h12, 4'b1000, 8);
    chk("valid_before_reset", o_valid[2], 1'b1);
    do_reset();
    start = cyc;
    issue(8'h12, 4'b1000, 20);
    chk("latency_after_reset", upd_cyc[3] - start, 18);

    // randomized pin streams
    ps = 8'h00; pd = 4'h0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        rs = ps; rd = pd;
      end else begin
        rn = $urandom_range(0, 9);
        if (rn < 7) rd = 4'(1 << $urandom_range(0, 3));
        else if (rn == 7) rd = 4'h0;
        else begin
          a = $urandom_range(0, 3);
          b = (a + $urandom_range(1, 3)) % 4;
          rd = 4'((1 << a) | (1 << b));
        end
        rn = $urandom_range(0, 9);
        if (rn < 7) rs = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
        else if (rn == 7) rs = {1'($urandom_range(0, 1)), 7'h7F};
        else rs = 8'($urandom);
      end
      issue(rs, rd, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 30));
      ps = rs; pd = rd;
    end
    issue(8'h00, 4'h0, 25);
    chk("queue_drained_random", q.size(), 0);

    // watchdog: digit 0 committed once, digit 1 kept fresh by rescanning
    do_reset();
    issue(8'h40, 4'b0001, 20);
    for (int i = 0; i < 215; i++) issue((i % 2) ? 8'h24 : 8'h79, 4'b0010, 20);
    chk("timeout_latency", fall_cyc[0] - upd_cyc[0], TO);
    chk("timeout_valid", o_valid[1:0], 2'b10);
    chk("timeout_data_held", o_hexa[3:0], 4'h0);
    chk("digit1_never_expired", fall_cyc[1], -1);
    issue(8'h00, 4'h0, 25);
    chk("queue_drained_end", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
